mac_neuron_q35: RTL and testbench

//   Streaming multiply-accumulate neuron. It is the stage directly upstream of the PReLU activation.
//   - Accepts N_TERMS (x, w) pairs in Q3.5 over a valid/ready handshake.
//   - Adds a Q3.5 bias, then rounds and saturates the sum back to Q3.5.
//   - Presents one pre-activation result per neuron on a valid/ready output that feeds the activation x_in.

---
 rtl/mac_neuron_q35_if.sv | 30 +++
 rtl/mac_neuron_q35.sv | 128 ++++++++++++
 tb/tb_mac_neuron_q35.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mac_neuron_q35_if.sv
// Handshake bundle for mac_neuron_q35.
//   master: producer of (x_in, w_in, bias) pairs and consumer of y_out.
//   slave : the neuron itself.
//   in_valid/in_ready  : input pair handshake; bias sampled on first beat only
//   x_in/w_in/bias     : signed Q(WIDTH-1-FRAC).FRAC operands
//   out_valid/out_ready: result handshake
//   y_out/sat          : signed result and saturation flag, qualified by out_valid
interface mac_neuron_q35_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x_in;
  logic [WIDTH-1:0] w_in;
  logic [WIDTH-1:0] bias;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y_out;
  logic             sat;

  modport master (
    output in_valid, x_in, w_in, bias, out_ready,
    input  in_ready, out_valid, y_out, sat
  );

  modport slave (
    input  in_valid, x_in, w_in, bias, out_ready,
    output in_ready, out_valid, y_out, sat
  );
endinterface

// File: rtl/mac_neuron_q35.sv
// Streaming multiply-accumulate neuron feeding the PReLU activation.
// Accumulates N_TERMS signed x*w products on top of a bias, then rounds
// (half-up) and saturates the sum back to the input Q format.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; discards any partial neuron
//   bus   : mac_neuron_q35_if slave (input pairs in, one result out)
module mac_neuron_q35 #(
  parameter int WIDTH     = 8,
  parameter int FRAC      = 5,
  parameter int N_TERMS   = 16,
  parameter int ACC_WIDTH = 24
) (
  input  logic            clk,
  input  logic            reset,
  mac_neuron_q35_if.slave bus
);

  localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);
  localparam logic signed [ACC_WIDTH-1:0] RND_HALF = ACC_WIDTH'(1 << (FRAC - 1));
  localparam logic signed [ACC_WIDTH-1:0] Y_MAX    = ACC_WIDTH'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] Y_MIN    = ACC_WIDTH'(-(1 << (WIDTH - 1)));

  typedef enum logic [1:0] {
    ACCUM,
    ROUND,
    OUT
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [CNT_W-1:0]             r_cnt;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic [WIDTH-1:0]             r_y;
  logic                         r_sat;

  logic                         w_in_ready;
  logic                         w_out_valid;
  logic                         w_beat;
  logic signed [2*WIDTH-1:0]    w_x_ext;
  logic signed [2*WIDTH-1:0]    w_w_ext;
  logic signed [2*WIDTH-1:0]    w_prod;
  logic signed [ACC_WIDTH-1:0]  w_prod_ext;
  logic signed [ACC_WIDTH-1:0]  w_bias_ext;
  logic signed [ACC_WIDTH-1:0]  w_rnd;

  // Operands widened before multiplying so the 2*WIDTH product is exact.
  assign w_x_ext    = {{WIDTH{bus.x_in[WIDTH-1]}}, bus.x_in};
  assign w_w_ext    = {{WIDTH{bus.w_in[WIDTH-1]}}, bus.w_in};
  assign w_prod     = w_x_ext * w_w_ext;
  assign w_prod_ext = ACC_WIDTH'(w_prod);
  // Bias aligned to the product's 2*FRAC fractional bits.
  assign w_bias_ext = ACC_WIDTH'($signed(bus.bias)) <<< FRAC;
  assign w_rnd      = (r_acc + RND_HALF) >>> FRAC;

  assign w_beat     = bus.in_valid & w_in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ACCUM: begin
        w_in_ready = 1'b1;
        if (w_beat && (r_cnt == LAST_CNT)) begin
          w_state_nxt = ROUND;
        end
      end
      ROUND: begin
        w_state_nxt = OUT;
      end
      OUT: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_nxt = ACCUM;
        end
      end
      default: begin
        w_state_nxt = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_y   <= '0;
      r_sat <= 1'b0;
    end else begin
      if (w_beat) begin
        // First beat restarts the sum from the bias; no explicit clear needed.
        if (r_cnt == '0) begin
          r_acc <= w_bias_ext + w_prod_ext;
        end else begin
          r_acc <= r_acc + w_prod_ext;
        end
        r_cnt <= (r_cnt == LAST_CNT) ? '0 : r_cnt + 1'b1;
      end
      if (r_state == ROUND) begin
        if (w_rnd > Y_MAX) begin
          r_y   <= {1'b0, {(WIDTH-1){1'b1}}};
          r_sat <= 1'b1;
        end else if (w_rnd < Y_MIN) begin
          r_y   <= {1'b1, {(WIDTH-1){1'b0}}};
          r_sat <= 1'b1;
        end else begin
          r_y   <= w_rnd[WIDTH-1:0];
          r_sat <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.y_out     = r_y;
  assign bus.sat       = r_sat;

endmodule

// File: tb/tb_mac_neuron_q35.sv
// Directed bench for mac_neuron_q35 with N_TERMS=4, WIDTH=8, FRAC=5.
module tb_mac_neuron_q35;

  logic clk = 1'b0;
  logic reset;
  int   n_vec  = 0;
  int   n_miss = 0;
  longint t_out = 0;

  always #5 clk = ~clk;

  mac_neuron_q35_if #(.WIDTH(8)) bus ();

  mac_neuron_q35 #(
    .WIDTH    (8),
    .FRAC     (5),
    .N_TERMS  (4),
    .ACC_WIDTH(24)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one pair at a negedge and hold it until it is taken.
  task automatic beat(input logic [7:0] x, input logic [7:0] w, input logic [7:0] b);
    int guard;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.x_in     = x;
    bus.w_in     = w;
    bus.bias     = b;
    guard = 0;
    while (!bus.in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.x_in     = 8'h7f;
    bus.w_in     = 8'h7f;
    bus.bias     = 8'h7f;
  endtask

  // Counts negedges from just after the last beat until out_valid.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    t_out = $time;
    if (!bus.out_valid) check("out_valid_timeout", 0, 1);
  endtask

  task automatic neuron(input string tag, input logic [7:0] x, input logic [7:0] w,
                        input logic [7:0] b, input int exp_y, input int exp_sat);
    int lat;
    for (int i = 0; i < 4; i++) beat(x, w, (i == 0) ? b : (b ^ 8'h5a));
    wait_out(lat);
    check({tag, "_lat"}, lat, 2);
    check({tag, "_y"}, int'($signed(bus.y_out)), exp_y);
    check({tag, "_sat"}, int'(bus.sat), exp_sat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat;
    int accepted;
    int guard;
    logic v;
    logic [7:0] y_hold;
    logic sat_hold;
    longint t1;
    longint t2;

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.x_in      = '0;
    bus.w_in      = '0;
    bus.bias      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_y", int'(bus.y_out), 0);
    check("rst_sat", int'(bus.sat), 0);
    reset = 1'b0;

    // Mid-range and saturation cases
    neuron("mid", 8'd16, 8'd32, 8'd32, 96, 0);
    neuron("sat_pos", 8'd32, 8'd32, 8'd0, 127, 1);
    neuron("sat_neg", 8'hE0, 8'd32, 8'hE0, -128, 1);
    neuron("exact_min", 8'hE0, 8'd32, 8'd0, -128, 0);

    // Rounding
    neuron("rnd_half", 8'd1, 8'd4, 8'd0, 1, 0);
    neuron("rnd_neg_half", 8'hFF, 8'd4, 8'd0, 0, 0);
    neuron("rnd_small", 8'd1, 8'd1, 8'd0, 0, 0);

    // Random in_valid: only handshaken beats count; idle cycles carry junk
    accepted = 0;
    guard = 0;
    while (accepted < 4 && guard < 200) begin
      @(negedge clk);
      v = 1'($urandom_range(0, 1));
      bus.in_valid = v;
      if (v) begin
        bus.x_in = 8'd16;
        bus.w_in = 8'd32;
        bus.bias = (accepted == 0) ? 8'd32 : 8'h77;
        if (bus.in_ready) accepted++;
      end else begin
        bus.x_in = 8'h7f;
        bus.w_in = 8'h7f;
        bus.bias = 8'h7f;
      end
      guard++;
    end
    check("toggle_beats", accepted, 4);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_out(lat);
    check("toggle_lat", lat, 2);
    check("toggle_y", int'($signed(bus.y_out)), 96);
    @(posedge clk);
    #1;

    // Backpressure: result frozen, inputs refused
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(8'd32, 8'd32, 8'd0);
    wait_out(lat);
    y_hold   = bus.y_out;
    sat_hold = bus.sat;
    check("bp_y", int'($signed(y_hold)), 127);
    check("bp_sat", int'(sat_hold), 1);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.x_in     = 8'd5;
      bus.w_in     = 8'd7;
      bus.bias     = 8'd9;
      @(negedge clk);
      check("bp_hold_y", int'(bus.y_out), int'(y_hold));
      check("bp_hold_sat", int'(bus.sat), int'(sat_hold));
      check("bp_in_ready", int'(bus.in_ready), 0);
      check("bp_out_valid", int'(bus.out_valid), 1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release", int'(bus.out_valid), 0);
    neuron("after_bp", 8'd1, 8'd4, 8'd0, 1, 0);

    // Reset mid-neuron
    beat(8'd32, 8'd32, 8'd32);
    beat(8'd32, 8'd32, 8'd32);
    @(negedge clk);
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.x_in     = 8'd32;
    bus.w_in     = 8'd32;
    @(negedge clk);
    check("rstmid_out_valid", int'(bus.out_valid), 0);
    check("rstmid_in_ready", int'(bus.in_ready), 1);
    check("rstmid_y", int'(bus.y_out), 0);
    @(negedge clk);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rstpost_out_valid", int'(bus.out_valid), 0);
    neuron("post_rst", 8'd16, 8'd32, 8'd32, 96, 0);

    // Back-to-back neurons: one result every 6 cycles
    neuron("b2b_0", 8'd16, 8'd32, 8'd32, 96, 0);
    t1 = t_out;
    neuron("b2b_1", 8'd1, 8'd4, 8'd0, 1, 0);
    t2 = t_out;
    check("b2b_period_a", int'((t2 - t1) / 10), 6);
    neuron("b2b_2", 8'hE0, 8'd32, 8'd0, -128, 0);
    check("b2b_period_b", int'((t_out - t2) / 10), 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
